// File: rtl/elevator_scan_ctrl.sv
// Elevator car controller: latches panel calls and serves them in SCAN order.
// Optional homing to floor 0 after IDLE_TICKS idle cycles: define ELEV_IDLE_HOME_EN.
module elevator_scan_ctrl #(
    parameter int unsigned FLOORS     = 3,
    parameter int unsigned MOVE_TICKS = 2,
    parameter int unsigned DOOR_TICKS = 2,
    parameter int unsigned IDLE_TICKS = 8
) (
    input  logic                      FRQ,
    input  logic                      RST,
    input  logic [FLOORS-1:0]         interior_panel,
    input  logic [FLOORS-1:0]         exterior_panel,
    output logic [1:0]                engine,
    output logic [FLOORS-1:0]         doors,
    output logic [$clog2(FLOORS)-1:0] floor,
    output logic [FLOORS-1:0]         pending
);

    localparam int unsigned FW  = $clog2(FLOORS);
    localparam int unsigned MCW = $clog2(MOVE_TICKS + 1);
    localparam int unsigned DCW = $clog2(DOOR_TICKS + 1);

    localparam logic [MCW-1:0] MoveLast = MCW'(MOVE_TICKS - 1);
    localparam logic [DCW-1:0] DoorLast = DCW'(DOOR_TICKS - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMove = 2'd1;
    localparam logic [1:0] StDoor = 2'd2;

    localparam logic [1:0] EngStop = 2'b00;
    localparam logic [1:0] EngUp   = 2'b01;
    localparam logic [1:0] EngDown = 2'b10;

    if (FLOORS < 2 || MOVE_TICKS < 1 || DOOR_TICKS < 1 || IDLE_TICKS < 1) begin : gen_param_check
        $error("elevator_scan_ctrl: illegal parameter value");
    end

    logic [1:0]        state_q, state_d;
    logic              dir_q, dir_d;      // 1 = up
    logic [FW-1:0]     floor_q, floor_d;
    logic [1:0]        engine_q, engine_d;
    logic [FLOORS-1:0] doors_q, doors_d;
    logic [FLOORS-1:0] pending_q, pending_d;
    logic [MCW-1:0]    move_cnt_q, move_cnt_d;
    logic [DCW-1:0]    door_cnt_q, door_cnt_d;

    logic [FW-1:0]     next_floor;
    logic [FLOORS-1:0] calls;
    logic [FLOORS-1:0] set_mask;
    logic [FLOORS-1:0] clr_mask;

`ifdef ELEV_IDLE_HOME_EN
    localparam int unsigned ICW = $clog2(IDLE_TICKS + 1);
    localparam logic [ICW-1:0] IdleLast = ICW'(IDLE_TICKS - 1);

    logic [ICW-1:0] idle_cnt_q, idle_cnt_d;
    logic           homing_q, homing_d;
`endif

    function automatic logic calls_ahead(input logic [FLOORS-1:0] p, input logic [FW-1:0] f,
                                         input logic up);
        calls_ahead = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (p[i] && (up ? (i > int'(f)) : (i < int'(f)))) begin
                calls_ahead = 1'b1;
            end
        end
    endfunction

    function automatic logic [FLOORS-1:0] one_hot(input logic [FW-1:0] f);
        one_hot = {{(FLOORS-1){1'b0}}, 1'b1} << f;
    endfunction

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        floor_d    = floor_q;
        engine_d   = engine_q;
        doors_d    = doors_q;
        move_cnt_d = move_cnt_q;
        door_cnt_d = door_cnt_q;
        next_floor = dir_q ? floor_q + 1'b1 : floor_q - 1'b1;
        calls      = interior_panel | exterior_panel;
        set_mask   = calls;
        clr_mask   = '0;
`ifdef ELEV_IDLE_HOME_EN
        idle_cnt_d = '0;
        homing_d   = homing_q;
`endif

        case (state_q)
            StIdle: begin
                if (pending_q[floor_q]) begin
                    state_d    = StDoor;
                    doors_d    = one_hot(floor_q);
                    clr_mask   = one_hot(floor_q);
                    door_cnt_d = '0;
                end else if (calls_ahead(pending_q, floor_q, dir_q)) begin
                    state_d    = StMove;
                    engine_d   = dir_q ? EngUp : EngDown;
                    move_cnt_d = '0;
                end else if (calls_ahead(pending_q, floor_q, !dir_q)) begin
                    state_d    = StMove;
                    dir_d      = !dir_q;
                    engine_d   = dir_q ? EngDown : EngUp;
                    move_cnt_d = '0;
                end
`ifdef ELEV_IDLE_HOME_EN
                else if (floor_q != '0) begin
                    if (idle_cnt_q == IdleLast) begin
                        state_d    = StMove;
                        dir_d      = 1'b0;
                        engine_d   = EngDown;
                        homing_d   = 1'b1;
                        move_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
`endif
            end

            StMove: begin
                if (move_cnt_q == MoveLast) begin
                    move_cnt_d = '0;
                    floor_d    = next_floor;
                    if (pending_q[next_floor]) begin
                        state_d    = StDoor;
                        engine_d   = EngStop;
                        doors_d    = one_hot(next_floor);
                        clr_mask   = one_hot(next_floor);
                        door_cnt_d = '0;
                    end else if (calls_ahead(pending_q, next_floor, dir_q)) begin
                        state_d = StMove;
                    end
`ifdef ELEV_IDLE_HOME_EN
                    else if (homing_q && pending_q == '0 && next_floor != '0) begin
                        state_d = StMove;
                    end
`endif
                    else begin
                        state_d  = StIdle;
                        engine_d = EngStop;
                    end
`ifdef ELEV_IDLE_HOME_EN
                    // Any latched call cancels the homing trip at this boundary.
                    homing_d = homing_q && (pending_q == '0) && (next_floor != '0);
`endif
                end else begin
                    move_cnt_d = move_cnt_q + 1'b1;
                end
            end

            StDoor: begin
                // A call at the open floor just holds the door; it is never latched.
                if (calls[floor_q]) begin
                    door_cnt_d        = '0;
                    set_mask[floor_q] = 1'b0;
                end else if (door_cnt_q == DoorLast) begin
                    state_d    = StIdle;
                    doors_d    = '0;
                    door_cnt_d = '0;
                end else begin
                    door_cnt_d = door_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d  = StIdle;
                engine_d = EngStop;
                doors_d  = '0;
            end
        endcase

        pending_d = (pending_q | set_mask) & ~clr_mask;
    end

    always_ff @(posedge FRQ or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            dir_q      <= 1'b1;
            floor_q    <= '0;
            engine_q   <= EngStop;
            doors_q    <= '0;
            pending_q  <= '0;
            move_cnt_q <= '0;
            door_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            floor_q    <= floor_d;
            engine_q   <= engine_d;
            doors_q    <= doors_d;
            pending_q  <= pending_d;
            move_cnt_q <= move_cnt_d;
            door_cnt_q <= door_cnt_d;
        end
    end

`ifdef ELEV_IDLE_HOME_EN
    always_ff @(posedge FRQ or posedge RST) begin
        if (RST) begin
            idle_cnt_q <= '0;
            homing_q   <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            homing_q   <= homing_d;
        end
    end
`endif

    assign engine  = engine_q;
    assign doors   = doors_q;
    assign floor   = floor_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: vector table, directed corner sequences and a
// randomized run against a countdown-based reference model.
module tb_elevator_scan_ctrl;

    localparam int FL = 3;
    localparam int MT = 2;
    localparam int DT = 2;
    localparam int IT = 8;

    logic       FRQ = 1'b0;
    logic       RST;
    logic [2:0] interior_panel;
    logic [2:0] exterior_panel;
    logic [1:0] engine;
    logic [2:0] doors;
    logic [1:0] floor;
    logic [2:0] pending;

    int checks = 0;
    int errors = 0;

    elevator_scan_ctrl #(
        .FLOORS    (FL),
        .MOVE_TICKS(MT),
        .DOOR_TICKS(DT),
        .IDLE_TICKS(IT)
    ) dut (
        .FRQ           (FRQ),
        .RST           (RST),
        .interior_panel(interior_panel),
        .exterior_panel(exterior_panel),
        .engine        (engine),
        .doors         (doors),
        .floor         (floor),
        .pending       (pending)
    );

    always #5 FRQ = ~FRQ;

    typedef struct {
        logic [2:0] ip;
        logic [2:0] ep;
        logic [1:0] eng;
        logic [2:0] drs;
        logic [1:0] flr;
        logic [2:0] pnd;
    } vec_t;

    vec_t vecs[20];

    // Door-opening log used to verify service order.
    bit         log_on = 1'b0;
    logic [2:0] prev_doors = 3'b000;
    int         order[$];
    int         scan_exp[3] = '{1, 2, 0};

    // Reference model: countdowns of edges left in motion / with the door open.
    int      m_floor;
    bit      m_up;
    bit [2:0] m_pend;
    int      m_move_left;
    int      m_door_left;
    bit      m_home;
    int      m_idle;

    logic [2:0] r_ip;
    logic [2:0] r_ep;
    int         n;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, got, exp);
        end
    endtask

    task automatic tick(input logic [2:0] ip, input logic [2:0] ep);
        interior_panel = ip;
        exterior_panel = ep;
        @(posedge FRQ);
        #1;
        if (log_on && doors != 3'b000 && prev_doors == 3'b000) order.push_back(int'(floor));
        prev_doors = doors;
    endtask

    function automatic bit any_beyond(input bit [2:0] p, input int f, input bit up);
        for (int i = 0; i < FL; i++) begin
            if (p[i] && (up ? (i > f) : (i < f))) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_floor = 0; m_up = 1'b1; m_pend = '0;
        m_move_left = 0; m_door_left = 0; m_home = 1'b0; m_idle = 0;
    endtask

    task automatic model_step(input bit [2:0] calls_in);
        bit [2:0] p;
        bit [2:0] calls;
        bit [2:0] clr;
        int       idle_next;
        p = m_pend; calls = calls_in; clr = '0; idle_next = 0;
        if (m_door_left > 0) begin
            if (calls[m_floor]) begin
                m_door_left = DT;
                calls[m_floor] = 1'b0;
            end else begin
                m_door_left--;
            end
        end else if (m_move_left > 0) begin
            m_move_left--;
            if (m_move_left == 0) begin
                m_floor += m_up ? 1 : -1;
                if (p[m_floor]) begin
                    m_door_left = DT;
                    clr[m_floor] = 1'b1;
                end else if (any_beyond(p, m_floor, m_up)) begin
                    m_move_left = MT;
                end
`ifdef ELEV_IDLE_HOME_EN
                else if (m_home && p == 0 && m_floor != 0) m_move_left = MT;
                m_home = m_home && p == 0 && m_floor != 0;
`endif
            end
        end else begin
            if (p[m_floor]) begin
                m_door_left = DT;
                clr[m_floor] = 1'b1;
            end else if (any_beyond(p, m_floor, m_up)) begin
                m_move_left = MT;
            end else if (any_beyond(p, m_floor, !m_up)) begin
                m_up = !m_up;
                m_move_left = MT;
            end
`ifdef ELEV_IDLE_HOME_EN
            else if (m_floor != 0) begin
                idle_next = m_idle + 1;
                if (idle_next == IT) begin
                    idle_next = 0; m_home = 1'b1; m_up = 1'b0; m_move_left = MT;
                end
            end
`endif
        end
        m_idle = idle_next;
        m_pend = (p | calls) & ~clr;
    endtask

    function automatic logic [9:0] model_out();
        logic [1:0] e;
        logic [2:0] d;
        e = (m_move_left > 0) ? (m_up ? 2'b01 : 2'b10) : 2'b00;
        d = (m_door_left > 0) ? (3'b001 << m_floor) : 3'b000;
        return {e, d, 2'(m_floor), m_pend};
    endfunction

    initial begin
        vecs[0]  = '{3'b001, 3'b000, 2'b00, 3'b000, 2'd0, 3'b001};
        vecs[1]  = '{3'b000, 3'b000, 2'b00, 3'b001, 2'd0, 3'b000};
        vecs[2]  = '{3'b000, 3'b000, 2'b00, 3'b001, 2'd0, 3'b000};
        vecs[3]  = '{3'b000, 3'b000, 2'b00, 3'b000, 2'd0, 3'b000};
        vecs[4]  = '{3'b000, 3'b100, 2'b00, 3'b000, 2'd0, 3'b100};
        vecs[5]  = '{3'b000, 3'b000, 2'b01, 3'b000, 2'd0, 3'b100};
        vecs[6]  = '{3'b000, 3'b000, 2'b01, 3'b000, 2'd0, 3'b100};
        vecs[7]  = '{3'b000, 3'b000, 2'b01, 3'b000, 2'd1, 3'b100};
        vecs[8]  = '{3'b000, 3'b000, 2'b01, 3'b000, 2'd1, 3'b100};
        vecs[9]  = '{3'b000, 3'b000, 2'b00, 3'b100, 2'd2, 3'b000};
        vecs[10] = '{3'b000, 3'b000, 2'b00, 3'b100, 2'd2, 3'b000};
        vecs[11] = '{3'b000, 3'b000, 2'b00, 3'b000, 2'd2, 3'b000};
        vecs[12] = '{3'b000, 3'b001, 2'b00, 3'b000, 2'd2, 3'b001};
        vecs[13] = '{3'b000, 3'b000, 2'b10, 3'b000, 2'd2, 3'b001};
        vecs[14] = '{3'b000, 3'b000, 2'b10, 3'b000, 2'd2, 3'b001};
        vecs[15] = '{3'b000, 3'b000, 2'b10, 3'b000, 2'd1, 3'b001};
        vecs[16] = '{3'b000, 3'b000, 2'b10, 3'b000, 2'd1, 3'b001};
        vecs[17] = '{3'b000, 3'b000, 2'b00, 3'b001, 2'd0, 3'b000};
        vecs[18] = '{3'b000, 3'b000, 2'b00, 3'b001, 2'd0, 3'b000};
        vecs[19] = '{3'b000, 3'b000, 2'b00, 3'b000, 2'd0, 3'b000};

        // Reset held, then released with no calls.
        RST = 1'b1;
        interior_panel = '0;
        exterior_panel = '0;
        tick(3'b000, 3'b000);
        tick(3'b000, 3'b000);
        check("reset engine", 16'(engine), 16'h0);
        check("reset doors", 16'(doors), 16'h0);
        check("reset floor", 16'(floor), 16'h0);
        check("reset pending", 16'(pending), 16'h0);
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(3'b000, 3'b000);
            check($sformatf("quiet[%0d]", i), 16'({engine, doors, floor, pending}), 16'h0);
        end

        // Same-floor call, express run 0->2, reversal back to 0.
        for (int i = 0; i < 20; i++) begin
            tick(vecs[i].ip, vecs[i].ep);
            check($sformatf("vec[%0d] engine", i), 16'(engine), 16'(vecs[i].eng));
            check($sformatf("vec[%0d] doors", i), 16'(doors), 16'(vecs[i].drs));
            check($sformatf("vec[%0d] floor", i), 16'(floor), 16'(vecs[i].flr));
            check($sformatf("vec[%0d] pending", i), 16'(pending), 16'(vecs[i].pnd));
        end

        // Door re-open at floor 2.
        tick(3'b100, 3'b000);
        for (int i = 0; i < 5; i++) tick(3'b000, 3'b000);
        check("reopen arrive doors", 16'(doors), 16'b100);
        tick(3'b100, 3'b000);
        check("reopen press doors", 16'(doors), 16'b100);
        check("reopen press pending", 16'(pending), 16'h0);
        tick(3'b000, 3'b000);
        check("reopen held doors", 16'(doors), 16'b100);
        check("reopen held pending", 16'(pending), 16'h0);
        tick(3'b000, 3'b000);
        check("reopen closed doors", 16'(doors), 16'h0);

        // Asynchronous reset while moving down.
        tick(3'b000, 3'b001);
        tick(3'b000, 3'b000);
        check("pre-reset engine", 16'(engine), 16'b10);
        #2 RST = 1'b1;
        #1;
        check("async engine", 16'(engine), 16'h0);
        check("async floor", 16'(floor), 16'h0);
        check("async pending", 16'(pending), 16'h0);
        check("async doors", 16'(doors), 16'h0);
        #1 RST = 1'b0;

        // SCAN order: 1 and 2 latched going up, 0 pressed on leaving floor 1.
        order.delete();
        prev_doors = doors;
        log_on = 1'b1;
        tick(3'b010, 3'b100);
        for (int i = 0; i < 5; i++) tick(3'b000, 3'b000);
        tick(3'b001, 3'b000);
        check("scan leaving engine", 16'(engine), 16'b01);
        check("scan leaving floor", 16'(floor), 16'd1);
        for (int i = 0; i < 14; i++) tick(3'b000, 3'b000);
        log_on = 1'b0;
        check("scan stop count", 16'(order.size()), 16'd3);
        for (int i = 0; i < order.size() && i < 3; i++) begin
            check($sformatf("scan stop[%0d]", i), 16'(order[i]), 16'(scan_exp[i]));
        end

`ifdef ELEV_IDLE_HOME_EN
        // Homing: park at floor 2, expect a down trip after IT idle edges.
        RST = 1'b1; #1 RST = 1'b0;
        tick(3'b100, 3'b000);
        n = 0;
        while (doors != 3'b100 && n < 20) begin tick(3'b000, 3'b000); n++; end
        while (doors != 3'b000 && n < 40) begin tick(3'b000, 3'b000); n++; end
        check("home door cycle bound", 16'(n < 40), 16'd1);
        n = 0;
        while (engine != 2'b10 && n < 20) begin tick(3'b000, 3'b000); n++; end
        check("home idle edges", 16'(n), 16'(IT));
        n = 0;
        while (!(floor == 2'd0 && engine == 2'b00) && n < 20) begin
            tick(3'b000, 3'b000);
            check($sformatf("home door shut[%0d]", n), 16'(doors), 16'h0);
            n++;
        end
        check("home arrival bound", 16'(n < 20), 16'd1);
        check("home arrival floor", 16'(floor), 16'd0);
        check("home arrival pending", 16'(pending), 16'h0);
`endif

        // Randomized traffic against the reference model.
        RST = 1'b1;
        tick(3'b000, 3'b000);
        RST = 1'b0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 3; b++) begin
                r_ip[b] = ($urandom_range(0, 7) == 0);
                r_ep[b] = ($urandom_range(0, 15) == 0);
            end
            model_step(r_ip | r_ep);
            tick(r_ip, r_ep);
            check($sformatf("rand[%0d] {eng,doors,floor,pend}", c),
                  16'({engine, doors, floor, pending}), 16'(model_out()));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/elevator_scan_ctrl.md
# elevator_scan_ctrl

Parametrised elevator car controller for `FLOORS` landings. It latches interior and exterior call buttons into a pending-request register and serves them in SCAN order: it continues in the current direction while calls remain ahead, then reverses. It drives a 2-bit engine command and a one-hot door-open vector, with per-floor travel time and door dwell counted in `FRQ` cycles. It is the multi-floor, scheduling successor of the existing `movement` block and sits between the panel decoders and the motor/door drivers.

## Interface
- `FLOORS`, default 3: number of landings, ≥2.
- `MOVE_TICKS`, default 2: `FRQ` cycles to travel one floor, ≥1.
- `DOOR_TICKS`, default 2: `FRQ` cycles the door stays open, ≥1.
- `IDLE_TICKS`, default 8: idle cycles before the car returns to floor 0. Used only with `ELEV_IDLE_HOME_EN`.
- `FRQ` in, 1: clock; all state changes on the rising edge.
- `RST` in, 1: asynchronous, active-high reset.
- `interior_panel` in, `FLOORS`: car buttons, bit i = floor i, level-sampled.
- `exterior_panel` in, `FLOORS`: hall buttons, bit i = floor i, level-sampled.
- `engine` out, 2: 00 stop, 01 up, 10 down; 11 is never driven.
- `doors` out, `FLOORS`: one-hot open door at the current floor; all zero when closed.
- `floor` out, `$clog2(FLOORS)`: current floor index.
- `pending` out, `FLOORS`: latched outstanding calls.

## Operation
- Reset values: `engine`=00, `doors`=0, `floor`=0, `pending`=0, direction=up, state IDLE, all counters 0.
- Call latching:
  - Every edge sets `pending[i]` if `interior_panel[i] | exterior_panel[i]`.
  - `pending[i]` clears on the edge that opens the door at floor i.
  - If a set and a clear for the same bit occur on the same edge, the clear wins.
- State IDLE:
  - Decision uses the registered `pending` and `floor`.
  - If `pending[floor]`: go to DOOR.
  - Else if any call lies ahead in the current direction: go to MOVE in that direction.
  - Else if any call lies behind: flip direction and go to MOVE.
  - Else stay in IDLE.
- State MOVE:
  - `engine` = 01 or 10; a move counter counts to `MOVE_TICKS`.
  - On the `MOVE_TICKS`-th edge, `floor` steps by ±1 and the counter reloads.
  - On that same edge, if `pending[new floor]`: go to DOOR (`engine`=00, door opens, bit cleared).
  - Otherwise, if a call lies ahead, keep moving; otherwise go to IDLE with `engine`=00.
  - Intermediate floors without a call are passed without stopping.
- State DOOR:
  - `doors` = one-hot of `floor`; `engine`=00.
  - Lasts `DOOR_TICKS` edges, then IDLE with `doors`=0.
  - A call for the current floor while in DOOR reloads the dwell counter and does not set `pending`.
- Floor bounds: the car never commands up at floor `FLOORS-1` or down at floor 0. The scheduling rules above guarantee this; it is not a separate check.
- `engine`≠00 and `doors`≠0 are mutually exclusive in every cycle.

## Timing
- All outputs are registered.
- Button asserted before edge k → `pending` is set after edge k → the IDLE decision is made at edge k+1.
- From IDLE, a call d floors away opens the door at edge k+1+d·`MOVE_TICKS`.
- Door-close to next decision: one IDLE cycle.
- `RST` asserted mid-move or mid-door clears everything immediately, without waiting for an edge.

## Configuration
- `ELEV_IDLE_HOME_EN` defined:
  - An idle counter counts consecutive IDLE cycles with `pending`=0 and `floor`≠0.
  - When it reaches `IDLE_TICKS`, the block sets direction=down and enters MOVE toward floor 0. The car arrives with `engine`=00, no door opening and no `pending` change.
  - Any new call aborts the homing trip; normal SCAN resumes at the next floor boundary.
- Not defined: the car parks at its last floor indefinitely; the idle counter is not built.

## Test plan
Parameters for all scenarios: `FLOORS`=3, `MOVE_TICKS`=2, `DOOR_TICKS`=2.
- Reset: hold `RST`=1 → `engine`=00, `doors`=000, `floor`=0, `pending`=000. Deassert with no calls → outputs stay unchanged for 20 cycles.
- Same-floor call: at floor 0, pulse `interior_panel`=001 for one cycle → `pending`=001 for one cycle, then `doors`=001 for 2 cycles, `engine` stays 00.
- Express run: at floor 0, pulse `exterior_panel`=100 → `engine`=01 for 4 cycles; `floor` goes 1 then 2 with no stop at 1; then `doors`=100 for 2 cycles and `pending`=000.
- SCAN order: car moving up from 0, latch calls 010 and 100, then press 001 while leaving floor 1 → service order is floor 1, then 2, then reverse to 0.
- Door re-open: press `interior_panel`=100 during DOOR at floor 2 → dwell extends 2 cycles from the press; `pending[2]` stays 0.
- Reset mid-move: assert `RST` while `engine`=10 → `engine`=00, `floor`=0, `pending`=0 with no clock edge needed. With `ELEV_IDLE_HOME_EN` and `IDLE_TICKS`=8: idle at floor 2 → `engine`=10 after 8 cycles, arrival at floor 0 with `doors`=000.
